// File: rtl/uart_tx_module_if.sv
// Handshake bundle between user logic and the UART transmitter.
//   tx_en   : request to send tx_data (honoured only while busy is low)
//   tx_data : byte to send, captured on the accepting edge
//   busy    : transmitter owns the line, from acceptance to end of last stop bit
//   tx_done : one-cycle pulse when a frame completes
// master = user logic side, slave = transmitter side.
interface uart_tx_module_if;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       busy;
    logic       tx_done;

    modport master (
        output tx_en,
        output tx_data,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  tx_en,
        input  tx_data,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_module.sv
// UART transmitter: serialises one byte per handshake as
// start bit, 8 data bits LSB-first, optional parity bit, 1 or 2 stop bits.
// Bit timing is BIT_CYCLES = CLK_FREQ/BAUD system clocks per bit.
// Ports:
//   sysclk : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   link   : handshake bundle (tx_en, tx_data in; busy, tx_done out)
//   tx     : registered serial output, idle high
module uart_tx_module #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,        // 0 none, 1 odd, 2 even
    parameter int STOP_BITS = 1         // 1 or 2
) (
    input  logic              sysclk,
    input  logic              rst_n,
    uart_tx_module_if.slave   link,
    output logic              tx
);

    localparam int          BIT_CYCLES = CLK_FREQ / BAUD;
    localparam logic [15:0] CNT_LAST   = 16'(BIT_CYCLES - 1);
    // Value of the stop-bit counter during the final stop bit.
    localparam logic        STOP_LAST  = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]  state_reg;
    logic [15:0] cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        parity_reg;
    logic        stop_cnt_reg;
    logic        tx_reg;
    logic        busy_reg;
    logic        done_reg;

    logic bit_end;
    assign bit_end = (cnt_reg == CNT_LAST);

    assign tx           = tx_reg;
    assign link.busy    = busy_reg;
    assign link.tx_done = done_reg;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            stop_cnt_reg <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == S_IDLE) begin
                cnt_reg <= '0;
                if (link.tx_en && !busy_reg) begin
                    shift_reg    <= link.tx_data;
                    parity_reg   <= (PARITY == 1) ? ~^link.tx_data : ^link.tx_data;
                    state_reg    <= S_START;
                    tx_reg       <= 1'b0;
                    busy_reg     <= 1'b1;
                    bit_idx_reg  <= '0;
                    stop_cnt_reg <= 1'b0;
                end
            end else begin
                cnt_reg <= bit_end ? 16'd0 : cnt_reg + 16'd1;
                if (bit_end) begin
                    case (state_reg)
                        S_START: begin
                            state_reg   <= S_DATA;
                            tx_reg      <= shift_reg[0];
                            bit_idx_reg <= '0;
                        end
                        S_DATA: begin
                            if (bit_idx_reg == 3'd7) begin
                                if (PARITY != 0) begin
                                    state_reg <= S_PARITY;
                                    tx_reg    <= parity_reg;
                                end else begin
                                    state_reg    <= S_STOP;
                                    tx_reg       <= 1'b1;
                                    stop_cnt_reg <= 1'b0;
                                end
                            end else begin
                                // Shift right so the next bit is always at [1] before the shift.
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                                shift_reg   <= {1'b0, shift_reg[7:1]};
                                tx_reg      <= shift_reg[1];
                            end
                        end
                        S_PARITY: begin
                            state_reg    <= S_STOP;
                            tx_reg       <= 1'b1;
                            stop_cnt_reg <= 1'b0;
                        end
                        S_STOP: begin
                            if (stop_cnt_reg == STOP_LAST) begin
                                state_reg <= S_IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                tx_reg    <= 1'b1;
                            end else begin
                                stop_cnt_reg <= 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                            tx_reg    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule
